// File: rtl/write_channel.sv
// write_channel: AXI4 S2MM write channel. Takes one single-burst command,
// issues one INCR burst on AW, passes stream beats through to W, collects
// the B response and reports busy / sticky error status.
module write_channel #(
   parameter int DMA_DATA_WIDTH_DST = 64,
   parameter int DMA_AXI_ADDR_WIDTH = 32
) (
   input  logic                            m_axi_aclk,
   input  logic                            m_axi_areset,
   output logic [DMA_AXI_ADDR_WIDTH-1:0]   m_s2mm_axi_awaddr,
   output logic [1:0]                      m_s2mm_axi_awburst,
   output logic [3:0]                      m_s2mm_axi_awcache,
   output logic [7:0]                      m_s2mm_axi_awlen,
   output logic [2:0]                      m_s2mm_axi_awprot,
   output logic [2:0]                      m_s2mm_axi_awsize,
   output logic                            m_s2mm_axi_awvalid,
   input  logic                            m_s2mm_axi_awready,
   output logic [DMA_DATA_WIDTH_DST-1:0]   m_s2mm_axi_wdata,
   output logic [DMA_DATA_WIDTH_DST/8-1:0] m_s2mm_axi_wstrb,
   output logic                            m_s2mm_axi_wlast,
   output logic                            m_s2mm_axi_wvalid,
   input  logic                            m_s2mm_axi_wready,
   input  logic [1:0]                      m_s2mm_axi_bresp,
   input  logic                            m_s2mm_axi_bvalid,
   output logic                            m_s2mm_axi_bready,
   input  logic [DMA_DATA_WIDTH_DST-1:0]   s_s2mm_axis_tdata,
   input  logic                            s_s2mm_axis_tvalid,
   input  logic                            s_s2mm_axis_tlast,
   output logic                            s_s2mm_axis_tready,
   input  logic                            write_start_i,
   input  logic [DMA_AXI_ADDR_WIDTH-1:0]   write_addr_i,
   input  logic [7:0]                      write_len_i,
   input  logic [2:0]                      write_size_i,
   output logic                            write_busy_o,
   output logic                            write_error_o,
   output logic                            write_tlast_err_o
);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t     state, state_nxt;
   logic       start_q;
   logic       start;
   logic       xfer;
   logic       aw_hs, w_hs, b_hs;
   logic       aw_done, w_done;
   logic [7:0] beat_cnt;

   // Rising-edge detect on the command strobe; only honoured in IDLE.
   assign start = write_start_i & ~start_q & (state == IDLE);
   assign xfer  = (state == XFER);

   // Fixed AW attributes and full write strobes.
   assign m_s2mm_axi_awburst = 2'b01;
   assign m_s2mm_axi_awcache = 4'b0011;
   assign m_s2mm_axi_awprot  = 3'b000;
   assign m_s2mm_axi_wstrb   = '1;

   // W is a straight pass-through of the stream, closed once the last beat is taken.
   assign m_s2mm_axi_wdata   = s_s2mm_axis_tdata;
   assign m_s2mm_axi_wvalid  = s_s2mm_axis_tvalid & ~w_done & xfer;
   assign s_s2mm_axis_tready = m_s2mm_axi_wready & ~w_done & xfer;
   assign m_s2mm_axi_wlast   = (beat_cnt == 8'd0);

   assign m_s2mm_axi_bready  = (state == RESP);
   assign write_busy_o       = (state != IDLE);

   assign aw_hs = m_s2mm_axi_awvalid & m_s2mm_axi_awready;
   assign w_hs  = m_s2mm_axi_wvalid & m_s2mm_axi_wready;
   assign b_hs  = m_s2mm_axi_bvalid & m_s2mm_axi_bready;

   // State register.
   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) state <= IDLE;
      else              state <= state_nxt;
   end

   // Next-state logic; AW and W completions may land on the same edge.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = XFER;
         XFER:    if ((aw_done | aw_hs) & (w_done | (w_hs & m_s2mm_axi_wlast)))
                     state_nxt = RESP;
         RESP:    if (b_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered copy of the command strobe for edge detection.
   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) start_q <= 1'b0;
      else              start_q <= write_start_i;
   end

   // Command latch, AW/W progress tracking, beat counter and sticky errors.
   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) begin
         m_s2mm_axi_awaddr  <= '0;
         m_s2mm_axi_awlen   <= '0;
         m_s2mm_axi_awsize  <= '0;
         m_s2mm_axi_awvalid <= 1'b0;
         aw_done            <= 1'b0;
         w_done             <= 1'b0;
         beat_cnt           <= '0;
         write_error_o      <= 1'b0;
         write_tlast_err_o  <= 1'b0;
      end else if (start) begin
         m_s2mm_axi_awaddr  <= write_addr_i;
         m_s2mm_axi_awlen   <= write_len_i;
         m_s2mm_axi_awsize  <= write_size_i;
         m_s2mm_axi_awvalid <= 1'b1;
         aw_done            <= 1'b0;
         w_done             <= 1'b0;
         beat_cnt           <= write_len_i;
         write_error_o      <= 1'b0;
         write_tlast_err_o  <= 1'b0;
      end else begin
         if (aw_hs) begin
            m_s2mm_axi_awvalid <= 1'b0;
            aw_done            <= 1'b1;
         end
         if (w_hs) begin
            beat_cnt <= beat_cnt - 8'd1;
            if (m_s2mm_axi_wlast) w_done <= 1'b1;
            if (s_s2mm_axis_tlast != m_s2mm_axi_wlast) write_tlast_err_o <= 1'b1;
         end
         if (b_hs && (m_s2mm_axi_bresp != 2'b00)) write_error_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_write_channel.sv
// tb_write_channel: command vectors from a table, W beats checked against a
// scoreboard queue filled from the generated stream, plus hand-written
// sequences for a dropped mid-burst start and an asynchronous reset.
module tb_write_channel;

   localparam int DW = 64;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [AW-1:0]   awaddr;
   logic [1:0]      awburst;
   logic [3:0]      awcache;
   logic [7:0]      awlen;
   logic [2:0]      awprot;
   logic [2:0]      awsize;
   logic            awvalid;
   logic            awready = 1'b0;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready = 1'b0;
   logic [1:0]      bresp = 2'b00;
   logic            bvalid = 1'b0;
   logic            bready;
   logic [DW-1:0]   tdata = '0;
   logic            tvalid = 1'b0;
   logic            tlast = 1'b0;
   logic            tready;
   logic            start = 1'b0;
   logic [AW-1:0]   cmd_addr = '0;
   logic [7:0]      cmd_len = '0;
   logic [2:0]      cmd_size = '0;
   logic            busy;
   logic            err;
   logic            tlast_err;

   int vectors = 0;
   int fails   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  bresp;
      int          tlast_pos;
      int          aw_delay;
      bit          rnd;
      bit          w_first;
      bit          exp_err;
      bit          exp_tlast;
   } vec_t;

   vec_t        vecs[7];
   logic [DW:0] expq[$];
   logic [DW-1:0] stream[$];

   write_channel #(.DMA_DATA_WIDTH_DST(DW), .DMA_AXI_ADDR_WIDTH(AW)) dut (
      .m_axi_aclk(clk),              .m_axi_areset(rst),
      .m_s2mm_axi_awaddr(awaddr),    .m_s2mm_axi_awburst(awburst),
      .m_s2mm_axi_awcache(awcache),  .m_s2mm_axi_awlen(awlen),
      .m_s2mm_axi_awprot(awprot),    .m_s2mm_axi_awsize(awsize),
      .m_s2mm_axi_awvalid(awvalid),  .m_s2mm_axi_awready(awready),
      .m_s2mm_axi_wdata(wdata),      .m_s2mm_axi_wstrb(wstrb),
      .m_s2mm_axi_wlast(wlast),      .m_s2mm_axi_wvalid(wvalid),
      .m_s2mm_axi_wready(wready),    .m_s2mm_axi_bresp(bresp),
      .m_s2mm_axi_bvalid(bvalid),    .m_s2mm_axi_bready(bready),
      .s_s2mm_axis_tdata(tdata),     .s_s2mm_axis_tvalid(tvalid),
      .s_s2mm_axis_tlast(tlast),     .s_s2mm_axis_tready(tready),
      .write_start_i(start),         .write_addr_i(cmd_addr),
      .write_len_i(cmd_len),         .write_size_i(cmd_size),
      .write_busy_o(busy),           .write_error_o(err),
      .write_tlast_err_o(tlast_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one command and act as stream source and AXI slave until B completes.
   task automatic run_cmd(input vec_t v, input int id);
      int  sidx = 0;
      int  wbeats = 0;
      int  aw_cnt = 0;
      int  cyc = 0;
      bit  done = 0;
      logic [DW:0] e;
      stream.delete();
      expq.delete();
      for (int k = 0; k <= int'(v.len); k++) begin
         stream.push_back({$urandom, $urandom});
         expq.push_back({(k == int'(v.len)), stream[k]});
      end
      @(negedge clk);
      start = 1'b1; cmd_addr = v.addr; cmd_len = v.len; cmd_size = v.size;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d_busy_start", id), busy, 1);
      check($sformatf("v%0d_err_clear", id), err, 0);
      check($sformatf("v%0d_tlast_err_clear", id), tlast_err, 0);
      while (!done && cyc < 2000) begin
         awready = (cyc >= v.aw_delay);
         wready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bvalid  = 1'b1;
         bresp   = v.bresp;
         if (sidx <= int'(v.len)) begin
            tvalid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tdata  = stream[sidx];
            tlast  = (sidx == v.tlast_pos);
         end else begin
            tvalid = 1'b0;
            tlast  = 1'b0;
         end
         #1;
         if (awvalid && awready) begin
            aw_cnt++;
            check($sformatf("v%0d_awaddr", id), awaddr, v.addr);
            check($sformatf("v%0d_awlen", id), awlen, v.len);
            check($sformatf("v%0d_awsize", id), awsize, v.size);
            check($sformatf("v%0d_aw_const", id), {awburst, awcache, awprot, wstrb},
                  {2'b01, 4'b0011, 3'b000, 8'hff});
            if (v.w_first) check($sformatf("v%0d_w_before_aw", id), wbeats, int'(v.len) + 1);
         end
         if (wvalid && wready) begin
            if (expq.size() == 0) begin
               check($sformatf("v%0d_extra_beat", id), 1, 0);
            end else begin
               e = expq.pop_front();
               check($sformatf("v%0d_wdata%0d", id, wbeats), wdata, e[DW-1:0]);
               check($sformatf("v%0d_wlast%0d", id, wbeats), wlast, e[DW]);
            end
            wbeats++;
         end
         if (tvalid && tready) sidx++;
         if (bvalid && bready) begin
            check($sformatf("v%0d_b_after_w", id), wbeats, int'(v.len) + 1);
            check($sformatf("v%0d_b_after_aw", id), aw_cnt, 1);
            done = 1;
         end
         @(negedge clk);
         cyc++;
      end
      if (!done) check($sformatf("v%0d_timeout", id), 1, 0);
      bvalid = 1'b0; tvalid = 1'b0; wready = 1'b0; awready = 1'b0;
      check($sformatf("v%0d_busy_end", id), busy, 0);
      check($sformatf("v%0d_error", id), err, v.exp_err);
      check($sformatf("v%0d_tlast_err", id), tlast_err, v.exp_tlast);
      check($sformatf("v%0d_q_empty", id), expq.size(), 0);
      check($sformatf("v%0d_aw_count", id), aw_cnt, 1);
   endtask

   initial begin
      //          addr      len    size   bresp  tpos aw_d rnd wfst err tle
      vecs[0] = '{32'h1000, 8'd3,  3'd3, 2'b00,   3,  0,  0,  0,  0,  0};
      vecs[1] = '{32'h1000, 8'd3,  3'd3, 2'b00,   3, 10,  0,  1,  0,  0};
      vecs[2] = '{32'h2000, 8'd0,  3'd3, 2'b00, 255,  0,  0,  0,  0,  1};
      vecs[3] = '{32'h3000, 8'd15, 3'd3, 2'b00,  15,  2,  1,  0,  0,  0};
      vecs[4] = '{32'h4000, 8'd7,  3'd3, 2'b10,   7,  0,  0,  0,  1,  0};
      vecs[5] = '{32'h5000, 8'd1,  3'd2, 2'b00,   1,  0,  0,  0,  0,  0};
      vecs[6] = '{32'h6000, 8'd3,  3'd3, 2'b00,   1,  0,  0,  0,  0,  1};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_awvalid", awvalid, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_bready", bready, 0);
      check("rst_busy", busy, 0);
      check("rst_error", err, 0);
      check("rst_tlast_err", tlast_err, 0);

      for (int i = 0; i < 7; i++) run_cmd(vecs[i], i);

      // Second start mid-burst is dropped; async reset mid-burst kills all valids.
      awready = 1'b0; wready = 1'b1; tvalid = 1'b1; tlast = 1'b0; bvalid = 1'b1;
      @(negedge clk);
      start = 1'b1; cmd_addr = 32'h6000; cmd_len = 8'd7; cmd_size = 3'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; cmd_addr = 32'h7000; cmd_len = 8'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_awvalid", awvalid, 1);
      check("mid_awaddr_kept", awaddr, 32'h6000);
      check("mid_awlen_kept", awlen, 8'd7);
      check("mid_bready", bready, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_awvalid", awvalid, 0);
      check("arst_wvalid", wvalid, 0);
      check("arst_tready", tready, 0);
      check("arst_bready", bready, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_awvalid", awvalid, 0);
      tvalid = 1'b0; wready = 1'b0; bvalid = 1'b0;

      run_cmd(vecs[0], 99);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/write_channel.md
Name: write_channel

Overview:
- AXI4 S2MM write channel of the DMA: accepts a single-burst write command, issues one INCR burst on AW and streams AXI-Stream beats onto W.
- Collects the B response and reports busy and error status.
- Counterpart of the MM2S read channel; sits between the stream source (encoder output) and the memory interconnect.

Parameters:
- DMA_DATA_WIDTH_DST, 64, data width of the W channel and of the input stream (multiple of 8).
- DMA_AXI_ADDR_WIDTH, 32, AXI address width.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_areset  in  1  reset, asynchronous, active-high
- m_s2mm_axi_awaddr  out  DMA_AXI_ADDR_WIDTH  burst start address
- m_s2mm_axi_awburst  out  2  constant 2'b01 (INCR)
- m_s2mm_axi_awcache  out  4  constant 4'b0011 (normal non-cacheable bufferable)
- m_s2mm_axi_awlen  out  8  beats-1
- m_s2mm_axi_awprot  out  3  constant 0
- m_s2mm_axi_awsize  out  3  bytes per beat, log2
- m_s2mm_axi_awvalid  out  1  address valid
- m_s2mm_axi_awready  in  1  address ready
- m_s2mm_axi_wdata  out  DMA_DATA_WIDTH_DST  write data
- m_s2mm_axi_wstrb  out  DMA_DATA_WIDTH_DST/8  constant all ones
- m_s2mm_axi_wlast  out  1  final beat of burst
- m_s2mm_axi_wvalid  out  1  data valid
- m_s2mm_axi_wready  in  1  data ready
- m_s2mm_axi_bresp  in  2  write response
- m_s2mm_axi_bvalid  in  1  response valid
- m_s2mm_axi_bready  out  1  response ready
- s_s2mm_axis_tdata  in  DMA_DATA_WIDTH_DST  stream data
- s_s2mm_axis_tvalid  in  1  stream valid
- s_s2mm_axis_tlast  in  1  stream end-of-packet
- s_s2mm_axis_tready  out  1  stream ready
- write_start_i  in  1  command strobe (rising edge)
- write_addr_i  in  DMA_AXI_ADDR_WIDTH  command address
- write_len_i  in  8  command beats-1
- write_size_i  in  3  command beat size
- write_busy_o  out  1  transfer in progress
- write_error_o  out  1  sticky: bresp != OKAY
- write_tlast_err_o  out  1  sticky: tlast misaligned with burst end

Behaviour:
- Reset (async): state IDLE; awvalid, wvalid, bready, write_busy_o, write_error_o and write_tlast_err_o all 0. awaddr/awlen/awsize/beat counter are don't-care.
- Start: write_start_i is registered; start = write_start_i & !registered copy. Start is accepted only in IDLE; a start while busy is dropped (not queued).
- On accepted start (cycle N), at edge N+1:
  - awaddr/awlen/awsize latch the command inputs.
  - beat counter loads write_len_i.
  - awvalid=1, write_busy_o=1, both sticky errors clear.
  - State goes to XFER.
- XFER, AW side: awvalid holds until the awready handshake, then 0 and aw_done=1. AW and W proceed concurrently and independently; W may finish before AW.
- XFER, W side (pass-through):
  - wdata = tdata.
  - wvalid = tvalid & !w_done.
  - s_s2mm_axis_tready = wready & !w_done, in XFER only; 0 in all other states.
- Per W handshake: counter decrements. wlast = (counter==0) combinationally. The handshake with wlast sets w_done. Burst framing comes only from awlen; tlast never ends or extends the burst.
- tlast check: write_tlast_err_o sets if a beat is accepted with tlast != wlast.
- Leaving XFER: when aw_done & w_done (handshakes may coincide on one edge), go to RESP; bready=1.
- RESP: on bvalid & bready, bready=0 and state IDLE. If bresp != 2'b00, write_error_o sets. write_busy_o falls on that same edge, so a new start is accepted from the next cycle.
- Stray bvalid outside RESP is ignored (bready=0).
- Reset mid-burst: all valids drop immediately; no completion is reported.

Test Plan:
- Reset, then start addr=0x1000 len=3 size=3, stream 4 beats with tlast on beat 4, awready/wready/bvalid always 1 -> one AW (awlen=3, awsize=3), 4 W beats, wlast on beat 4 only, busy high until B handshake, no errors.
- Same command with awready held low 10 cycles while wready=1 -> all 4 W beats complete first, RESP entered only after AW handshake.
- len=0 -> single beat with wlast=1; tlast=0 on that beat -> write_tlast_err_o=1, burst still completes.
- tvalid and wready toggled pseudo-randomly over len=15 -> exactly 16 beats, data order preserved, no beat accepted after wlast.
- bresp=2'b10 -> write_error_o=1 after completion; next start clears it.
- Second start pulse mid-burst, then async reset asserted mid-burst -> second command ignored; after reset, all valids and busy are 0.
